// File: rtl/subtractor_64bit_seq_if.sv
// rtl/subtractor_64bit_seq_if.sv - operand/result handshake bundle for the sequential subtractor
interface subtractor_64bit_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/subtractor_64bit_seq.sv
// rtl/subtractor_64bit_seq.sv - multi-cycle a - b - borrow_in, one slice per clock, LSB slice first
module subtractor_64bit_seq #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    subtractor_64bit_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   diff_q;
    logic [WIDTH-1:0]   diff_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q;
    logic               borrow_out_q, overflow_q, zero_q;
    logic [SLICE_W:0]   slice_res;
    logic               last_slice;
    logic               in_ready_c, out_valid_c;

    assign last_slice = (cnt_q == LAST);

    // Current slice difference with the running borrow; the extra top bit is the borrow out of the slice
    always_comb begin
        slice_res = {1'b0, a_q[cnt_q*SLICE_W +: SLICE_W]}
                  - {1'b0, b_q[cnt_q*SLICE_W +: SLICE_W]}
                  - {{SLICE_W{1'b0}}, borrow_q};
        diff_next = work_q;
        diff_next[cnt_q*SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; ready/valid depend on state only
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice-by-slice accumulation, and result/flag registration on the last slice.
    // Visible results live in diff_q so they stay put while the next operation is computing.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            work_q       <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.borrow_in;
                        cnt_q    <= '0;
                        work_q   <= '0;
                    end
                end
                BUSY: begin
                    work_q   <= diff_next;
                    borrow_q <= slice_res[SLICE_W];
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_slice) begin
                        diff_q       <= diff_next;
                        borrow_out_q <= slice_res[SLICE_W];
                        overflow_q   <= (a_q[MSB] != b_q[MSB]) && (diff_next[MSB] != a_q[MSB]);
                        zero_q       <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.zero       = zero_q;

endmodule

// File: tb/tb_subtractor_64bit_seq.sv
// tb/tb_subtractor_64bit_seq.sv - directed and random checks of subtractor_64bit_seq
module tb_subtractor_64bit_seq;
    logic clk = 1'b0;
    logic rst;

    subtractor_64bit_seq_if #(.WIDTH(64)) bus ();

    subtractor_64bit_seq #(.WIDTH(64), .SLICE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        exp_t e;
        logic [64:0] full;
        full   = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        e.diff = full[63:0];
        e.bout = full[64];
        e.ovf  = (a[63] != b[63]) && (full[63] != a[63]);
        e.zero = (full[63:0] == 64'd0);
        return e;
    endfunction

    // Drive operands at a negedge and push the expected result; returns after the accept edge
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bin, input exp_t e);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.a         = ~a;
        bus.b         = ~b;
        bus.borrow_in = ~bin;
    endtask

    // Wait for out_valid (bounded), check latency and fields, then leave it in DONE at a negedge
    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_diff"}, bus.diff, e.diff);
            check({tag, "_borrow_out"}, {63'd0, bus.borrow_out}, {63'd0, e.bout});
            check({tag, "_overflow"}, {63'd0, bus.overflow}, {63'd0, e.ovf});
            check({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, e.zero});
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input exp_t e);
        send(a, b, bin, e);
        wait_result(tag);
        take_result();
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.zero = z;
        return e;
    endfunction

    initial begin
        exp_t        e;
        logic [63:0] ra, rb;
        logic        rbin;
        int          seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_diff", bus.diff, 64'd0);
        check("rst_flags", {61'd0, bus.borrow_out, bus.overflow, bus.zero}, 64'd0);

        run_op("basic", 64'd5, 64'd3, 1'b0, mk(64'd2, 1'b0, 1'b0, 1'b0));
        run_op("underflow", 64'd0, 64'd1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));
        run_op("xslice", 64'h0000_0001_0000_0000, 64'd0, 1'b1,
               mk(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
        run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
               mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0));
        run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               mk(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0));
        run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
               mk(64'd0, 1'b0, 1'b0, 1'b1));
        run_op("all_borrow", 64'd0, 64'd0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 4; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rbin = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rbin, model(ra, rb, rbin));
        end

        // Backpressure: hold DONE while new operands are presented
        send(64'd100, 64'd1, 1'b0, mk(64'd99, 1'b0, 1'b0, 1'b0));
        wait_result("bp");
        bus.in_valid  = 1'b1;
        bus.a         = 64'h0000_0000_0001_0000;
        bus.b         = 64'd1;
        bus.borrow_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("bp_hold_diff", bus.diff, 64'd99);
        end
        exp_q.push_back(mk(64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
        check("bp_diff_kept", bus.diff, 64'd99);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_prev_diff_held_in_busy", bus.diff, 64'd99);
        seen = 0;
        while (!bus.out_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("bp_second_latency", 64'(seen), 64'd4);
        e = exp_q.pop_front();
        check("bp_second_diff", bus.diff, e.diff);
        take_result();

        // Reset during the second BUSY cycle aborts the operation
        send(64'd50, 64'd7, 1'b0, mk(64'd43, 1'b0, 1'b0, 1'b0));
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("abort_diff", bus.diff, 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);

        run_op("post_reset", 64'd10, 64'd10, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
